// File: rtl/ldpcenc_pack_if.sv
// Byte-in / 27-bit-word-out handshake bundle between the upstream source,
// the LDPC input packer and the encoder.
interface ldpcenc_pack_if;
  logic        vld_in;
  logic        sop_in;
  logic [3:0]  mode_in;
  logic [7:0]  byte_in;
  logic        rdy_in;
  logic        vld_out;
  logic        sop_out;
  logic [3:0]  mode_out;
  logic [26:0] data_out;
  logic        rdy_out;
  logic        err_out;

  modport slave (
    input  vld_in, sop_in, mode_in, byte_in, rdy_out,
    output rdy_in, vld_out, sop_out, mode_out, data_out, err_out
  );

  modport master (
    output vld_in, sop_in, mode_in, byte_in, rdy_out,
    input  rdy_in, vld_out, sop_out, mode_out, data_out, err_out
  );
endinterface

// File: rtl/ldpcenc_pack.sv
// Packs an LSB-first byte stream of LDPC information bits into 27-bit words
// for the encoder; word/byte counts per codeword come from the mode tables.
module ldpcenc_pack (
  input  logic           clk,
  input  logic           srst,
  ldpcenc_pack_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RECV  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  // Reserved length code 3 aliases to the 648-bit codeword.
  function automatic logic [5:0] f_words(input logic [3:0] m);
    logic [1:0] len;
    len = (m[3:2] == 2'd3) ? 2'd0 : m[3:2];
    case ({len, m[1:0]})
      4'd0:    f_words = 6'd12;
      4'd1:    f_words = 6'd16;
      4'd2:    f_words = 6'd18;
      4'd3:    f_words = 6'd20;
      4'd4:    f_words = 6'd24;
      4'd5:    f_words = 6'd32;
      4'd6:    f_words = 6'd36;
      4'd7:    f_words = 6'd40;
      4'd8:    f_words = 6'd36;
      4'd9:    f_words = 6'd48;
      4'd10:   f_words = 6'd54;
      4'd11:   f_words = 6'd60;
      default: f_words = 6'd12;
    endcase
  endfunction

  function automatic logic [7:0] f_bytes(input logic [3:0] m);
    logic [1:0] len;
    len = (m[3:2] == 2'd3) ? 2'd0 : m[3:2];
    case ({len, m[1:0]})
      4'd0:    f_bytes = 8'd41;
      4'd1:    f_bytes = 8'd54;
      4'd2:    f_bytes = 8'd61;
      4'd3:    f_bytes = 8'd68;
      4'd4:    f_bytes = 8'd81;
      4'd5:    f_bytes = 8'd108;
      4'd6:    f_bytes = 8'd122;
      4'd7:    f_bytes = 8'd135;
      4'd8:    f_bytes = 8'd122;
      4'd9:    f_bytes = 8'd162;
      4'd10:   f_bytes = 8'd183;
      4'd11:   f_bytes = 8'd203;
      default: f_bytes = 8'd41;
    endcase
  endfunction

  logic [1:0]  r_state;
  logic [34:0] r_acc;
  logic [5:0]  r_nbits;
  logic [7:0]  r_bcnt;
  logic [5:0]  r_wcnt;
  logic [3:0]  r_mode;
  logic        r_err;

  logic        w_accept;
  logic        w_xfer;
  logic [34:0] w_acc_sh;
  logic [5:0]  w_nb_sh;
  logic [34:0] w_acc_wr;

  assign bus.vld_out  = (r_state != S_IDLE) && (r_nbits >= 6'd27) && (r_wcnt != 6'd0);
  assign bus.sop_out  = bus.vld_out && (r_wcnt == f_words(r_mode));
  assign bus.data_out = r_acc[26:0];
  assign bus.mode_out = r_mode;
  assign bus.err_out  = r_err;
  assign bus.rdy_in   = !srst && ((r_state == S_IDLE) ||
                                  ((r_state == S_RECV) && (r_nbits < 6'd27)));

  assign w_accept = bus.vld_in && bus.rdy_in;
  assign w_xfer   = bus.vld_out && bus.rdy_out;

  // Bits above nbits are always zero, so a new byte can simply be OR-ed in.
  assign w_acc_sh = w_xfer ? (r_acc >> 27) : r_acc;
  assign w_nb_sh  = w_xfer ? (r_nbits - 6'd27) : r_nbits;
  assign w_acc_wr = w_acc_sh | ({27'd0, bus.byte_in} << w_nb_sh);

  always_ff @(posedge clk) begin
    if (srst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_nbits <= '0;
      r_bcnt  <= '0;
      r_wcnt  <= '0;
      r_mode  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (bus.sop_in) begin
              r_mode  <= bus.mode_in;
              r_acc   <= {27'd0, bus.byte_in};
              r_nbits <= 6'd8;
              r_bcnt  <= f_bytes(bus.mode_in) - 8'd1;
              r_wcnt  <= f_words(bus.mode_in);
              r_state <= S_RECV;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_RECV: begin
          if (w_accept) begin
            r_acc   <= w_acc_wr;
            r_nbits <= w_nb_sh + 6'd8;
            r_bcnt  <= r_bcnt - 8'd1;
            if (bus.sop_in) r_err <= 1'b1;
            if (r_bcnt == 8'd1) r_state <= S_FLUSH;
          end else if (w_xfer) begin
            r_acc   <= w_acc_sh;
            r_nbits <= w_nb_sh;
          end
          if (w_xfer) r_wcnt <= r_wcnt - 6'd1;
        end
        S_FLUSH: begin
          if (w_xfer) begin
            r_wcnt <= r_wcnt - 6'd1;
            // Last word: leftover pad bits of the final byte are discarded.
            if (r_wcnt == 6'd1) begin
              r_acc   <= '0;
              r_nbits <= '0;
              r_state <= S_IDLE;
            end else begin
              r_acc   <= w_acc_sh;
              r_nbits <= w_nb_sh;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ldpcenc_pack.sv
// Randomized self-checking bench for ldpcenc_pack against a bit-level
// reference packer built from the codeword size/rate rules.
module tb_ldpcenc_pack;
  logic clk;
  logic srst;
  ldpcenc_pack_if bus();

  ldpcenc_pack dut (.clk(clk), .srst(srst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [7:0]  tx_bytes[$];
  logic [26:0] exp_words[$];
  logic [26:0] got_data[$];
  logic        got_sop[$];
  logic [3:0]  got_mode[$];
  int stall_bad, rdyin_bad, idle_stall, err_seen;
  bit timed_out;

  function automatic int k_bits(input logic [3:0] m);
    int len;
    int n;
    len = int'(m[3:2]);
    if (len == 3) len = 0;
    n = 648 * (len + 1);
    case (m[1:0])
      2'd0:    return n / 2;
      2'd1:    return n * 2 / 3;
      2'd2:    return n * 3 / 4;
      default: return n * 5 / 6;
    endcase
  endfunction

  function automatic int n_words(input logic [3:0] m);
    return k_bits(m) / 27;
  endfunction

  function automatic int n_bytes(input logic [3:0] m);
    return (k_bits(m) + 7) / 8;
  endfunction

  // Reference: bit k of the stream is bit k%8 of byte k/8; word w holds bits 27w..27w+26.
  task automatic build_expected(input logic [3:0] m);
    logic [26:0] wd;
    logic [7:0]  bv;
    int k;
    exp_words.delete();
    for (int w = 0; w < n_words(m); w++) begin
      wd = '0;
      for (int b = 0; b < 27; b++) begin
        k = 27 * w + b;
        bv = tx_bytes[k / 8];
        wd[b] = bv[k % 8];
      end
      exp_words.push_back(wd);
    end
  endtask

  task automatic drive_packet(input logic [3:0] mode, input int nsend, input int exp_nw,
                              input int rdy_pct, input int sop_at);
    int idx, cyc, drain;
    bit prev_stall, started;
    logic [26:0] h_data;
    logic        h_sop;
    logic [3:0]  h_mode;
    idx = 0; cyc = 0; drain = 0; prev_stall = 0; started = 0;
    h_data = '0; h_sop = 0; h_mode = '0;
    got_data.delete(); got_sop.delete(); got_mode.delete();
    stall_bad = 0; rdyin_bad = 0; idle_stall = 0; err_seen = 0; timed_out = 0;
    while (drain < 6) begin
      bus.vld_in  = (idx < nsend);
      bus.sop_in  = (idx == 0) || (idx == sop_at);
      bus.byte_in = (idx < nsend) ? tx_bytes[idx] : 8'h00;
      bus.mode_in = mode;
      bus.rdy_out = ($urandom_range(99) < rdy_pct);
      @(negedge clk);
      if (bus.vld_out && bus.rdy_in) rdyin_bad++;
      if (prev_stall && (!bus.vld_out || bus.data_out !== h_data ||
                         bus.sop_out !== h_sop || bus.mode_out !== h_mode)) stall_bad++;
      if (started && idx < nsend && !bus.rdy_in && !bus.vld_out) idle_stall++;
      if (bus.err_out) err_seen++;
      if (bus.vld_out && bus.rdy_out) begin
        got_data.push_back(bus.data_out);
        got_sop.push_back(bus.sop_out);
        got_mode.push_back(bus.mode_out);
      end
      prev_stall = bus.vld_out && !bus.rdy_out;
      h_data = bus.data_out; h_sop = bus.sop_out; h_mode = bus.mode_out;
      if (bus.vld_in && bus.rdy_in) begin idx++; started = 1; end
      if (idx >= nsend && got_data.size() >= exp_nw) drain++;
      cyc++;
      if (cyc > 4000) begin timed_out = 1; drain = 6; end
      @(posedge clk); #1;
    end
    bus.vld_in = 0; bus.sop_in = 0; bus.rdy_out = 1;
  endtask

  function automatic int count_word_mismatch();
    int bad = 0;
    for (int i = 0; i < exp_words.size() && i < got_data.size(); i++)
      if (got_data[i] !== exp_words[i]) bad++;
    return bad;
  endfunction

  function automatic int count_sop_bad();
    int bad = 0;
    for (int i = 0; i < got_sop.size(); i++)
      if (got_sop[i] !== (i == 0)) bad++;
    return bad;
  endfunction

  task automatic test_reset();
    srst = 1;
    bus.vld_in = 1; bus.sop_in = 1; bus.mode_in = 4'h0; bus.byte_in = 8'h55; bus.rdy_out = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if (bus.rdy_in !== 1'b0) $display("FAIL reset_rdy_in got %b exp 0", bus.rdy_in); else pass_cnt++;
    total_cnt++;
    if ({bus.vld_out, bus.sop_out, bus.err_out} !== 3'b000)
      $display("FAIL reset_flags got %b exp 000", {bus.vld_out, bus.sop_out, bus.err_out});
    else pass_cnt++;
    total_cnt++;
    if ({bus.data_out, bus.mode_out} !== 31'd0)
      $display("FAIL reset_data_mode got %h/%h exp 0/0", bus.data_out, bus.mode_out);
    else pass_cnt++;
    @(posedge clk); #1;
    srst = 0; bus.vld_in = 0; bus.sop_in = 0;
    @(negedge clk);
    total_cnt++;
    if (bus.rdy_in !== 1'b1) $display("FAIL reset_release_rdy got %b exp 1", bus.rdy_in); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_seq_mode0();
    tx_bytes.delete();
    for (int i = 0; i < 41; i++) tx_bytes.push_back(8'(i));
    build_expected(4'h0);
    drive_packet(4'h0, 41, 12, 100, -1);
    total_cnt++;
    if (got_data.size() !== 12 || timed_out)
      $display("FAIL seq_count got %0d exp 12 (timeout %0d)", got_data.size(), timed_out);
    else pass_cnt++;
    total_cnt++;
    if (got_data.size() == 0 || got_data[0] !== 27'h3020100)
      $display("FAIL seq_word0 got %h exp 3020100", got_data.size() ? got_data[0] : 27'h0);
    else pass_cnt++;
    total_cnt++;
    if (count_word_mismatch() !== 0) $display("FAIL seq_words mismatches %0d exp 0", count_word_mismatch());
    else pass_cnt++;
    total_cnt++;
    if (count_sop_bad() !== 0) $display("FAIL seq_sop bad %0d exp 0", count_sop_bad()); else pass_cnt++;
    total_cnt++;
    if (idle_stall !== 0) $display("FAIL seq_throughput stalls %0d exp 0", idle_stall); else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({bus.rdy_in, bus.vld_out} !== 2'b10)
      $display("FAIL seq_idle rdy_in/vld_out got %b exp 10", {bus.rdy_in, bus.vld_out});
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_max_ones();
    tx_bytes.delete();
    for (int i = 0; i < 203; i++) tx_bytes.push_back(8'hFF);
    build_expected(4'b1011);
    drive_packet(4'b1011, 203, 60, 100, -1);
    total_cnt++;
    if (got_data.size() !== 60 || timed_out)
      $display("FAIL ones_count got %0d exp 60", got_data.size());
    else pass_cnt++;
    total_cnt++;
    if (count_word_mismatch() !== 0) $display("FAIL ones_words mismatches %0d exp 0", count_word_mismatch());
    else pass_cnt++;
    total_cnt++;
    if (count_sop_bad() !== 0) $display("FAIL ones_sop bad %0d exp 0", count_sop_bad()); else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (bus.rdy_in !== 1'b1) $display("FAIL ones_idle rdy_in got %b exp 1", bus.rdy_in); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_random_stall();
    int mbad;
    tx_bytes.delete();
    for (int i = 0; i < n_bytes(4'b0101); i++) tx_bytes.push_back(8'($urandom));
    build_expected(4'b0101);
    drive_packet(4'b0101, n_bytes(4'b0101), n_words(4'b0101), 50, -1);
    total_cnt++;
    if (got_data.size() !== 32 || timed_out) $display("FAIL rand_count got %0d exp 32", got_data.size());
    else pass_cnt++;
    total_cnt++;
    if (count_word_mismatch() !== 0) $display("FAIL rand_words mismatches %0d exp 0", count_word_mismatch());
    else pass_cnt++;
    total_cnt++;
    if (stall_bad !== 0) $display("FAIL rand_stall_hold changes %0d exp 0", stall_bad); else pass_cnt++;
    total_cnt++;
    if (rdyin_bad !== 0) $display("FAIL rand_rdy_in_full got %0d exp 0", rdyin_bad); else pass_cnt++;
    mbad = 0;
    foreach (got_mode[i]) if (got_mode[i] !== 4'b0101) mbad++;
    total_cnt++;
    if (mbad !== 0) $display("FAIL rand_mode_out bad %0d exp 0", mbad); else pass_cnt++;
    total_cnt++;
    if (count_sop_bad() !== 0) $display("FAIL rand_sop bad %0d exp 0", count_sop_bad()); else pass_cnt++;
  endtask

  task automatic test_errors();
    int vseen;
    bus.vld_in = 1; bus.sop_in = 0; bus.byte_in = 8'hAA; bus.mode_in = 4'h0; bus.rdy_out = 1;
    @(posedge clk); #1;
    bus.vld_in = 0;
    @(negedge clk);
    total_cnt++;
    if (bus.err_out !== 1'b1) $display("FAIL err_idle_pulse got %b exp 1", bus.err_out); else pass_cnt++;
    vseen = bus.vld_out;
    @(negedge clk);
    total_cnt++;
    if (bus.err_out !== 1'b0) $display("FAIL err_idle_clear got %b exp 0", bus.err_out); else pass_cnt++;
    vseen += bus.vld_out;
    total_cnt++;
    if (vseen !== 0 || bus.rdy_in !== 1'b1)
      $display("FAIL err_idle_state vld %0d rdy_in %b exp 0/1", vseen, bus.rdy_in);
    else pass_cnt++;
    @(posedge clk); #1;
    tx_bytes.delete();
    for (int i = 0; i < 41; i++) tx_bytes.push_back(8'($urandom));
    build_expected(4'h0);
    drive_packet(4'h0, 41, 12, 100, 4);
    total_cnt++;
    if (err_seen !== 1) $display("FAIL err_mid_pulses got %0d exp 1", err_seen); else pass_cnt++;
    total_cnt++;
    if (got_data.size() !== 12 || count_word_mismatch() !== 0)
      $display("FAIL err_mid_words count %0d mism %0d exp 12/0", got_data.size(), count_word_mismatch());
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    tx_bytes.delete();
    for (int i = 0; i < 41; i++) tx_bytes.push_back(8'($urandom));
    drive_packet(4'h0, 20, 5, 100, -1);
    srst = 1;
    @(negedge clk);
    total_cnt++;
    if (bus.rdy_in !== 1'b0) $display("FAIL rstmid_rdy_during got %b exp 0", bus.rdy_in); else pass_cnt++;
    @(posedge clk); #1;
    srst = 0;
    @(negedge clk);
    total_cnt++;
    if ({bus.vld_out, bus.rdy_in} !== 2'b01)
      $display("FAIL rstmid_after vld/rdy got %b exp 01", {bus.vld_out, bus.rdy_in});
    else pass_cnt++;
    @(posedge clk); #1;
    tx_bytes.delete();
    for (int i = 0; i < 41; i++) tx_bytes.push_back(8'($urandom));
    build_expected(4'h0);
    drive_packet(4'h0, 41, 12, 100, -1);
    total_cnt++;
    if (got_data.size() !== 12 || count_word_mismatch() !== 0 || count_sop_bad() !== 0)
      $display("FAIL rstmid_packet count %0d mism %0d exp 12/0", got_data.size(), count_word_mismatch());
    else pass_cnt++;
  endtask

  task automatic test_reserved_len();
    int mbad;
    tx_bytes.delete();
    for (int i = 0; i < 41; i++) tx_bytes.push_back(8'($urandom));
    build_expected(4'b1100);
    drive_packet(4'b1100, 41, 12, 70, -1);
    total_cnt++;
    if (got_data.size() !== 12 || timed_out || count_word_mismatch() !== 0)
      $display("FAIL rsv_words count %0d mism %0d exp 12/0", got_data.size(), count_word_mismatch());
    else pass_cnt++;
    mbad = 0;
    foreach (got_mode[i]) if (got_mode[i] !== 4'b1100) mbad++;
    total_cnt++;
    if (mbad !== 0) $display("FAIL rsv_mode_out bad %0d exp 0", mbad); else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (bus.rdy_in !== 1'b1) $display("FAIL rsv_idle rdy_in got %b exp 1", bus.rdy_in); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  initial begin
    srst = 1;
    bus.vld_in = 0; bus.sop_in = 0; bus.mode_in = '0; bus.byte_in = '0; bus.rdy_out = 0;
    test_reset();
    test_seq_mode0();
    test_max_ones();
    test_random_stall();
    test_errors();
    test_reset_mid();
    test_reserved_len();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/ldpcenc_pack.md
Name: ldpcenc_pack

Overview:
Upstream input packer for the Wi-Fi LDPC encoder. It accepts one codeword's information bits as a byte stream, LSB-first. It packs them into 27-bit words and presents them to the encoder's vld/sop/mode/data/rdy input handshake. The number of words per codeword is set by mode, and surplus pad bits in the last byte are discarded.

Parameters:
none (mode tables fixed by the standard)

Ports:
clk  in  1  system clock
srst  in  1  synchronous reset, active high
vld_in  in  1  input byte valid
sop_in  in  1  first byte of codeword
mode_in  in  4  [1:0] rate (0=1/2, 1=2/3, 2=3/4, 3=5/6), [3:2] length (0=648, 1=1296, 2=1944, 3=reserved, treated as 648); sampled with sop byte
byte_in  in  8  information byte; bit 0 is first in time
rdy_in  out  1  packer can accept a byte
vld_out  out  1  27-bit word valid (to encoder vld_in)
sop_out  out  1  first word of codeword (to encoder sop_in)
mode_out  out  4  latched mode (to encoder mode_in)
data_out  out  27  packed word; bit 0 is earliest bit (to encoder data_in)
rdy_out  in  1  encoder ready (from encoder rdy_in)
err_out  out  1  one-cycle protocol-error pulse

Behaviour:
- Info bits: K = n*rate. Words per codeword W = K/27. Bytes per codeword B = ceil(K/8).
  - 648: W = 12/16/18/20; B = 41/54/61/68.
  - 1296: W = 24/32/36/40; B = 81/108/122/135.
  - 1944: W = 36/48/54/60; B = 122/162/183/203.
- Storage:
  - acc[34:0] accumulator.
  - nbits 0..34.
  - bcnt: bytes remaining.
  - wcnt: words remaining.
  - mode_r.
  - FSM: IDLE, RECV, FLUSH.
- A byte is accepted when vld_in & rdy_in. It is written at acc[nbits+7:nbits], and nbits += 8.
- A word is transferred when vld_out & rdy_out. acc shifts right 27 and nbits -= 27.
  - A byte accept and a word transfer in the same cycle combine: the byte is written at position nbits-27 after the shift.
- vld_out = (state != IDLE) & (nbits >= 27) & (wcnt != 0). It must not depend on rdy_out.
- data_out = acc[26:0]. mode_out = mode_r. sop_out = vld_out & (wcnt == W(mode_r)).
- While vld_out & !rdy_out, data_out, sop_out and mode_out hold stable.
- rdy_in:
  - 1 in IDLE.
  - In RECV, equals (nbits < 27).
  - 0 in FLUSH and while srst is high.
  - Never depends on vld_in or rdy_out.
- IDLE:
  - On accept with sop_in=1: latch mode_r = mode_in, load acc with the byte, nbits = 8, bcnt = B-1, wcnt = W, go to RECV.
  - On accept with sop_in=0: drop the byte, pulse err_out, stay in IDLE.
- RECV:
  - Each accepted byte decrements bcnt.
  - A byte accepted with sop_in=1 is treated as data and pulses err_out.
  - The byte accepted with bcnt==1 moves the FSM to FLUSH.
- FLUSH: emit words. The transfer with wcnt==1 returns the FSM to IDLE and clears acc and nbits, dropping the 8B-K (<8) pad bits. wcnt decrements on every transfer in RECV and FLUSH.
- Latency: the first word is valid the cycle after the 4th byte is accepted (nbits = 32).
- Throughput: when rdy_out is held high, the input stalls only while nbits >= 27.
- Reset values (srst high): state IDLE, acc 0, nbits 0, bcnt 0, wcnt 0, mode_r 0, vld_out 0, sop_out 0, data_out 0, err_out 0, rdy_in 0.
- Reset mid-packet: all partial data is discarded. rdy_in is 1 the first cycle after srst deasserts.

Test Plan:
1. Mode 0 (648, 1/2), bytes 0x00..0x28 back-to-back, rdy_out=1 -> exactly 12 words. Word0=0x3020100 with sop_out=1; sop_out=0 on words 1-11. After the 12th word: IDLE, rdy_in=1, nbits=0.
2. Mode 4'b1011 (1944, 5/6), 203 bytes of 0xFF -> 60 words of 0x7FFFFFF. sop_out only on the first word; the 4 pad bits are dropped; no 61st word.
3. Mode 4'b0101 (1296, 2/3), 108 random bytes, rdy_out random 50% -> 32 words bit-exact vs a software packer. Outputs stable during stalls; rdy_in low whenever nbits >= 27.
4. vld_in byte with sop_in=0 in IDLE -> err_out pulse, no vld_out. sop_in on byte 5 of a mode-0 packet -> err_out pulse, byte still packed, 12 words emitted.
5. srst high for 1 cycle after 20 bytes of a mode-0 packet -> next cycle vld_out=0, rdy_in=1. A following full mode-0 packet yields the correct 12 words.
6. mode_in=4'b1100 -> treated as 648, rate 1/2: 41 bytes accepted, 12 words, mode_out=4'b1100.
